// File: rtl/jpeg_buf_pkg.sv
// Shared definitions for the JPEG block ping-pong buffer: block geometry,
// zigzag-scan to raster index mapping, and MSB-first flat block layout helpers.
// Element 0 of a flat block occupies the most significant sample slot.
package jpeg_buf_pkg;

  localparam int BLK_DEPTH = 64;
  localparam int SAMPLE_W  = 10;

  typedef logic [SAMPLE_W-1:0]           sample_t;
  typedef logic [SAMPLE_W*BLK_DEPTH-1:0] flat_blk_t;

  // Raster index of the k-th coefficient in zigzag scan order, entry 0 in the MSBs.
  localparam logic [6*64-1:0] ZZ_TAB = {
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [5:0] zz_to_raster(input logic [5:0] k);
    return ZZ_TAB[6*(63-int'(k)) +: 6];
  endfunction

  // Bit offset of element idx in an MSB-first flat block.
  function automatic int elem_lsb(input int idx, input int width, input int depth);
    return width * (depth - 1 - idx);
  endfunction

  function automatic flat_blk_t pack_block(input sample_t blk [BLK_DEPTH]);
    flat_blk_t flat;
    flat = '0;
    for (int i = 0; i < BLK_DEPTH; i++)
      flat[elem_lsb(i, SAMPLE_W, BLK_DEPTH) +: SAMPLE_W] = blk[i];
    return flat;
  endfunction

  function automatic void unpack_block(input flat_blk_t flat, output sample_t blk [BLK_DEPTH]);
    for (int i = 0; i < BLK_DEPTH; i++)
      blk[i] = flat[elem_lsb(i, SAMPLE_W, BLK_DEPTH) +: SAMPLE_W];
  endfunction

endpackage

// File: rtl/block_bank.sv
// One block of sample storage: single-element write port or whole-block load.
// Writes land on the clock edge; rd_data is the registered contents, packed MSB-first.
// No handshake here; the parent decides when a write or load is allowed.
// Ports: clock/reset_n, wr_en/wr_addr/wr_data, load_en/load_data, rd_data.
module block_bank import jpeg_buf_pkg::*; #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 64,
  localparam int IW        = $clog2(DEPTH)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          wr_en,
  input  logic [IW-1:0]                 wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          load_en,
  input  logic [DATA_WIDTH*DEPTH-1:0]   load_data,
  output logic [DATA_WIDTH*DEPTH-1:0]   rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (load_en) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= load_data[elem_lsb(i, DATA_WIDTH, DEPTH) +: DATA_WIDTH];
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++)
      rd_data[elem_lsb(i, DATA_WIDTH, DEPTH) +: DATA_WIDTH] = mem[i];
  end

endmodule

// File: rtl/block_pingpong_buffer.sv
// Double-buffered block store: serial (raster/zigzag) or one-cycle parallel fill,
// block presented the cycle after its last beat / its load. in_ready drops while the
// write bank is still full, or while load_en/flush claim the cycle; out holds until taken.
// Ports: in_valid/in_ready/in_data/zigzag_en serial side, load_en/load_data/load_err,
// flush, out_valid/out_ready/out_data consumer side, fill_level = full bank count.
module block_pingpong_buffer import jpeg_buf_pkg::*; #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = BLK_DEPTH
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          zigzag_en,
  input  logic                          load_en,
  input  logic [DATA_WIDTH*DEPTH-1:0]   load_data,
  input  logic                          flush,
  output logic                          load_err,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH*DEPTH-1:0]   out_data,
  output logic [1:0]                    fill_level
);

  localparam int IW               = $clog2(DEPTH);
  localparam bit ZZ_OK            = (DEPTH == BLK_DEPTH);
  localparam logic [IW-1:0] LAST  = IW'(DEPTH - 1);

  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, rd_bank_q;
  logic [IW-1:0] wr_idx_q;
  logic          zz_mode_q;
  logic          load_err_q;

  logic          first_beat, zz_now, beat, last_beat, load_ok, consume;
  logic [IW-1:0] wr_addr;
  logic [DATA_WIDTH*DEPTH-1:0] rd_data [2];

  assign in_ready   = !full_q[wr_bank_q] && !load_en && !flush;
  assign beat       = in_valid && in_ready;
  assign first_beat = (wr_idx_q == '0);
  // The first beat of a block already uses the mode it samples.
  assign zz_now     = first_beat ? (zigzag_en && ZZ_OK) : zz_mode_q;
  assign last_beat  = beat && (wr_idx_q == LAST);
  // A parallel load may only start on a block boundary.
  assign load_ok    = load_en && !flush && !full_q[wr_bank_q] && first_beat;
  assign consume    = full_q[rd_bank_q] && out_ready;

  always_comb begin
    wr_addr = wr_idx_q;
    if (ZZ_OK && zz_now) wr_addr = IW'(zz_to_raster(6'(wr_idx_q)));
  end

  // Fill and drain touch different banks whenever both happen, so both apply.
  always_comb begin
    full_d = full_q;
    if (consume) full_d[rd_bank_q] = 1'b0;
    if (last_beat || load_ok) full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      zz_mode_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      load_err_q <= load_en && !load_ok;
      if (consume) rd_bank_q <= !rd_bank_q;
      if (last_beat || load_ok) wr_bank_q <= !wr_bank_q;
      if (flush) begin
        wr_idx_q <= '0;
      end else if (beat) begin
        wr_idx_q <= last_beat ? '0 : wr_idx_q + 1'b1;
        if (first_beat) zz_mode_q <= zz_now;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    block_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_bank (
      .clock      (clock),
      .reset_n    (reset_n),
      .wr_en      (beat && (wr_bank_q == 1'(b))),
      .wr_addr    (wr_addr),
      .wr_data    (in_data),
      .load_en    (load_ok && (wr_bank_q == 1'(b))),
      .load_data  (load_data),
      .rd_data    (rd_data[b])
    );
  end

  assign out_valid  = full_q[rd_bank_q];
  assign out_data   = rd_data[rd_bank_q];
  assign fill_level = {1'b0, full_q[0]} + {1'b0, full_q[1]};
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_block_pingpong_buffer.sv
// Self-checking bench for block_pingpong_buffer (DATA_WIDTH=10, DEPTH=64).
// Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
module tb_block_pingpong_buffer;

  localparam int DW = 10;
  localparam int D  = 64;
  localparam int BW = DW * D;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          in_valid, in_ready, zigzag_en, load_en, flush, load_err;
  logic          out_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [BW-1:0] load_data, out_data;
  logic [1:0]    fill_level;

  int total = 0;
  int bad   = 0;

  block_pingpong_buffer #(.DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .zigzag_en(zigzag_en), .load_en(load_en), .load_data(load_data),
    .flush(flush), .load_err(load_err), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .fill_level(fill_level)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, wanted finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] elem(input logic [BW-1:0] v, input int i);
    return v[DW*(D-1-i) +: DW];
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_data = '0; zigzag_en = 0; load_en = 0; flush = 0;
  endtask

  task automatic do_reset();
    idle();
    out_ready = 0;
    reset_n = 0;
    cyc();
    cyc();
    reset_n = 1;
  endtask

  // Offer one serial beat until accepted, bounded.
  task automatic send_beat(input logic [DW-1:0] v, input logic zz);
    bit ok = 0;
    in_valid = 1; in_data = v; zigzag_en = zz;
    for (int t = 0; t < 200; t++) begin
      #1;
      ok = in_ready;
      @(posedge clock);
      #1;
      if (ok) break;
    end
    in_valid = 0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL beat_timeout: in_ready never 1 for value %0d", v);
    end
  endtask

  task automatic drain_one();
    out_ready = 1;
    cyc();
    out_ready = 0;
  endtask

  // ---------------- reference model ----------------
  int          zz_ref [D];
  logic [BW-1:0] mq [$];
  logic [DW-1:0] cur [D];
  int          m_idx;
  bit          m_zz, m_err;

  // Zigzag order by walking the anti-diagonals of the 8x8 block.
  task automatic build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) for (int r = hi; r >= lo; r--) begin zz_ref[k] = r*8 + (s-r); k++; end
      else            for (int r = lo; r <= hi; r++) begin zz_ref[k] = r*8 + (s-r); k++; end
    end
  endtask

  function automatic logic [BW-1:0] pack_ref();
    logic [BW-1:0] v = '0;
    for (int i = 0; i < D; i++) v[DW*(D-1-i) +: DW] = cur[i];
    return v;
  endfunction

  task automatic model_reset();
    mq.delete(); m_idx = 0; m_zz = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit room = (mq.size() < 2);
    bit lok  = load_en && !flush && room && (m_idx == 0);
    bit bt   = in_valid && room && !load_en && !flush;
    int pos;
    m_err = load_en && !lok;
    if (mq.size() > 0 && out_ready) void'(mq.pop_front());
    if (flush) m_idx = 0;
    else if (lok) mq.push_back(load_data);
    else if (bt) begin
      if (m_idx == 0) m_zz = zigzag_en;
      pos = m_zz ? zz_ref[m_idx] : m_idx;
      cur[pos] = in_data;
      m_idx++;
      if (m_idx == D) begin mq.push_back(pack_ref()); m_idx = 0; end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic       in_valid, load_en, flush, out_ready;
    logic       exp_in_ready, exp_out_valid;
    logic [1:0] exp_fill;
    logic       exp_err;
  } vec_t;

  vec_t tbl [16];
  logic [BW-1:0] ramp, snap;

  initial begin
    tbl[0]  = '{0,0,0,0, 1,0,2'd0,0};
    tbl[1]  = '{0,1,0,0, 0,0,2'd0,0};
    tbl[2]  = '{0,0,0,0, 1,1,2'd1,0};
    tbl[3]  = '{0,1,0,0, 0,1,2'd1,0};
    tbl[4]  = '{0,0,0,0, 0,1,2'd2,0};
    tbl[5]  = '{0,1,0,0, 0,1,2'd2,0};
    tbl[6]  = '{0,0,0,0, 0,1,2'd2,1};
    tbl[7]  = '{0,0,0,1, 0,1,2'd2,0};
    tbl[8]  = '{0,0,0,0, 1,1,2'd1,0};
    tbl[9]  = '{1,1,1,0, 0,1,2'd1,0};
    tbl[10] = '{0,0,0,0, 1,1,2'd1,1};
    tbl[11] = '{0,0,0,1, 1,1,2'd1,0};
    tbl[12] = '{0,0,0,0, 1,0,2'd0,0};
    tbl[13] = '{1,1,0,0, 0,0,2'd0,0};
    tbl[14] = '{0,0,0,1, 1,1,2'd1,0};
    tbl[15] = '{0,0,0,0, 1,0,2'd0,0};

    for (int i = 0; i < D; i++) ramp[DW*(D-1-i) +: DW] = DW'(1023 - i);
    build_zz();
    load_data = '0;

    // Reset state, checked while reset is held.
    idle(); out_ready = 0; reset_n = 0;
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_fill", fill_level, 0);
    do_reset();

    // Table: single-cycle handshake/priority vectors, checked before each edge.
    load_data = ramp;
    for (int r = 0; r < 16; r++) begin
      in_valid = tbl[r].in_valid; in_data = 10'd77; load_en = tbl[r].load_en;
      flush = tbl[r].flush; out_ready = tbl[r].out_ready;
      #1;
      chk($sformatf("tbl%0d_in_ready", r), in_ready, tbl[r].exp_in_ready);
      chk($sformatf("tbl%0d_out_valid", r), out_valid, tbl[r].exp_out_valid);
      chk($sformatf("tbl%0d_fill", r), fill_level, tbl[r].exp_fill);
      chk($sformatf("tbl%0d_load_err", r), load_err, tbl[r].exp_err);
      if (r == 2) chk("tbl_load_lsb", out_data[9:0], 10'h3C0);
      cyc();
      idle(); out_ready = 0;
    end

    // Raster fill.
    do_reset();
    out_ready = 1;
    for (int k = 0; k < D; k++) begin
      send_beat(DW'(k), 0);
      if (k == 62) chk("raster_valid_early", out_valid, 0);
    end
    chk("raster_valid", out_valid, 1);
    chk("raster_e0", out_data[639:630], 0);
    chk("raster_e63", out_data[9:0], 63);
    cyc();
    chk("raster_consumed", fill_level, 0);
    out_ready = 0;

    // Zigzag fill, zigzag_en toggling after beat 0.
    for (int k = 0; k < D; k++) send_beat(DW'(k), (k % 2 == 0));
    chk("zz_e1", elem(out_data, 1), 1);
    chk("zz_e8", elem(out_data, 8), 2);
    chk("zz_e16", elem(out_data, 16), 3);
    chk("zz_e2", elem(out_data, 2), 5);
    chk("zz_e63", elem(out_data, 63), 63);
    drain_one();

    // Back-pressure: two blocks fill both banks, third block stalls.
    for (int b = 1; b <= 2; b++)
      for (int k = 0; k < D; k++) send_beat(DW'(b*64 + k), 0);
    #1;
    chk("bp_fill2", fill_level, 2);
    chk("bp_in_ready0", in_ready, 0);
    chk("bp_head", elem(out_data, 0), 64);
    snap = out_data;
    in_valid = 1; in_data = 10'd192;
    for (int t = 0; t < 5; t++) begin
      #1;
      chk("bp_stall_ready", in_ready, 0);
      cyc();
      chk("bp_stable", out_data, snap);
    end
    out_ready = 1;
    cyc();
    out_ready = 0;
    #1;
    chk("bp_ready_back", in_ready, 1);
    chk("bp_next_head", elem(out_data, 0), 128);
    cyc();
    in_valid = 0;
    for (int k = 1; k < D; k++) send_beat(DW'(192 + k), 0);
    chk("bp_fill_again", fill_level, 2);
    drain_one();
    chk("bp_blk3_e0", elem(out_data, 0), 192);
    chk("bp_blk3_e63", elem(out_data, 63), 255);
    drain_one();
    chk("bp_empty", fill_level, 0);

    // Parallel load on empty buffer, then a load dropped mid-block.
    load_data = ramp; load_en = 1;
    cyc();
    load_en = 0;
    chk("pl_valid", out_valid, 1);
    chk("pl_lsb", out_data[9:0], 10'h3C0);
    chk("pl_e0", elem(out_data, 0), 10'h3FF);
    chk("pl_no_err", load_err, 0);
    drain_one();
    for (int k = 0; k < 5; k++) send_beat(DW'(300 + k), 0);
    load_en = 1;
    cyc();
    load_en = 0;
    chk("pl_err_pulse", load_err, 1);
    chk("pl_drop_valid", out_valid, 0);
    cyc();
    chk("pl_err_once", load_err, 0);
    for (int k = 5; k < D; k++) send_beat(DW'(300 + k), 0);
    chk("pl_partial_e0", elem(out_data, 0), 300);
    chk("pl_partial_e5", elem(out_data, 5), 305);
    chk("pl_partial_e63", elem(out_data, 63), 363);
    drain_one();

    // Flush with a simultaneous beat.
    for (int k = 0; k < 20; k++) send_beat(DW'(400 + k), 0);
    in_valid = 1; in_data = 10'd999; flush = 1;
    #1;
    chk("fl_in_ready0", in_ready, 0);
    cyc();
    idle();
    for (int k = 0; k < D; k++) begin
      send_beat(DW'(500 + k), 0);
      if (k == 62) chk("fl_not_early", out_valid, 0);
    end
    chk("fl_valid", out_valid, 1);
    chk("fl_e0", elem(out_data, 0), 500);
    chk("fl_e19", elem(out_data, 19), 519);
    chk("fl_e63", elem(out_data, 63), 563);
    drain_one();

    // Asynchronous reset mid-block with one bank full and load_err high.
    load_data = ramp; load_en = 1;
    cyc();
    load_en = 0;
    for (int k = 0; k < 30; k++) send_beat(DW'(k), 0);
    load_en = 1;
    cyc();
    load_en = 0;
    chk("ar_pre_err", load_err, 1);
    chk("ar_pre_fill", fill_level, 1);
    #2;
    reset_n = 0;
    #1;
    chk("ar_in_ready", in_ready, 1);
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_data", out_data, 0);
    chk("ar_fill", fill_level, 0);
    chk("ar_load_err", load_err, 0);
    cyc();
    reset_n = 1;
    for (int k = 0; k < D; k++) send_beat(DW'(600 + k), 0);
    chk("ar_clean_fill", fill_level, 1);
    chk("ar_clean_e0", elem(out_data, 0), 600);
    chk("ar_clean_e63", elem(out_data, 63), 663);

    // Randomised run against the queue model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      int pct = ((c / 500) % 3 == 0) ? 90 : (((c / 500) % 3 == 1) ? 10 : 50);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = DW'($urandom);
      zigzag_en = 1'($urandom);
      load_en   = ($urandom_range(0, 39) == 0);
      flush     = ($urandom_range(0, 99) == 0);
      out_ready = ($urandom_range(0, 99) < pct);
      for (int w = 0; w < BW/32; w++) load_data[32*w +: 32] = $urandom;
      #1;
      chk("rnd_in_ready", in_ready, (mq.size() < 2) && !load_en && !flush);
      chk("rnd_out_valid", out_valid, mq.size() > 0);
      chk("rnd_fill", fill_level, 2'(mq.size()));
      chk("rnd_load_err", load_err, m_err);
      if (mq.size() > 0) chk("rnd_out_data", out_data, mq[0]);
      model_step();
      cyc();
    end
    idle(); out_ready = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
